matmul_output_collector: RTL and testbench

Parametrised output collector for the weight/input-stationary systolic matmul flow. Captures per-column systolic-array outputs and per-column proxy (BISR spare) outputs into separate accumulators, forms each result element as their sum, and writes the finished ROWS×COLS matrix to memory one row per write. Sits between the matmul FSM/proxy datapath and the memory write port. It replaces derived-clock capture with fully synchronous capture and adds configurable hold period, multi-tile accumulation, overflow detection and an explicit start/done handshake.

---
 rtl/matmul_output_collector.sv | 212 +++++++++++++++++++++
 tb/tb_matmul_output_collector.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_output_collector.sv
// Output collector for the systolic matmul: captures array and proxy column outputs into separate
// accumulators and writes their sum to memory one row per write. Optional macro OUTPUT_SAT_EN selects saturating arithmetic.
module matmul_output_collector #(
  parameter int          ROWS               = 4,
  parameter int          COLS               = 4,
  parameter int          WORD_SIZE          = 16,
  parameter int          HOLD_CYCLES        = 2,
  parameter int          MEM_PORT_WIDTH     = 64,
  parameter logic [31:0] OUTPUT_BASE_ADDR   = 32'h0,
  parameter int          ADDR_INCR          = 1,
  parameter int          MEM_ACCESS_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          start,
  input  logic                          accumulate,
  input  logic                          fsm_done,
  input  logic [COLS*WORD_SIZE-1:0]     sa_out,
  input  logic [COLS-1:0]               sa_out_valid,
  input  logic [COLS*WORD_SIZE-1:0]     proxy_out,
  input  logic [COLS-1:0]               proxy_out_valid,
  output logic                          wr_output_rdy,
  output logic                          wr_output_done,
  output logic                          overflow,
  output logic [31:0]                   mem_addr,
  output logic                          mem_wr_en,
  output logic [MEM_PORT_WIDTH-1:0]     mem_data
);

  localparam int ROW_W  = $clog2(ROWS + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int LAT_W  = (MEM_ACCESS_LATENCY > 1) ? $clog2(MEM_ACCESS_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_MEM_WR, S_MEM_WR_DELAY, S_DONE
  } state_e;

  state_e                    state_q;
  logic [WORD_SIZE-1:0]      sa_acc_q [ROWS][COLS];
  logic [WORD_SIZE-1:0]      px_acc_q [ROWS][COLS];
  logic [ROW_W-1:0]          sa_row_q [COLS];
  logic [ROW_W-1:0]          px_row_q [COLS];
  logic [HOLD_W-1:0]         sa_hold_q [COLS];
  logic [HOLD_W-1:0]         px_hold_q [COLS];
  logic [ROW_W-1:0]          wr_row_q;
  logic [LAT_W-1:0]          lat_cnt_q;
  logic                      rdy_q;
  logic                      done_q;
  logic                      ovf_q;
  logic                      wr_en_q;
  logic [31:0]               addr_q;
  logic [MEM_PORT_WIDTH-1:0] data_q;
  logic [MEM_PORT_WIDTH-1:0] row_data_d;

  function automatic logic [WORD_SIZE-1:0] add_w(input logic [WORD_SIZE-1:0] a,
                                                 input logic [WORD_SIZE-1:0] b);
`ifdef OUTPUT_SAT_EN
    logic [WORD_SIZE:0] s;
    s = {a[WORD_SIZE-1], a} + {b[WORD_SIZE-1], b};
    if (s[WORD_SIZE] != s[WORD_SIZE-1])
      return s[WORD_SIZE] ? {1'b1, {(WORD_SIZE-1){1'b0}}} : {1'b0, {(WORD_SIZE-1){1'b1}}};
    return s[WORD_SIZE-1:0];
`else
    return a + b;
`endif
  endfunction

  always_comb begin
    row_data_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (wr_row_q == ROW_W'(r)) begin
        for (int c = 0; c < COLS; c++)
          row_data_d[c*WORD_SIZE +: WORD_SIZE] = add_w(sa_acc_q[r][c], px_acc_q[r][c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_row_q  <= '0;
      lat_cnt_q <= '0;
      for (int c = 0; c < COLS; c++) begin
        sa_row_q[c]  <= '0;
        px_row_q[c]  <= '0;
        sa_hold_q[c] <= '0;
        px_hold_q[c] <= '0;
        for (int r = 0; r < ROWS; r++) begin
          sa_acc_q[r][c] <= '0;
          px_acc_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_COLLECT;
            rdy_q   <= 1'b0;
            ovf_q   <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
              sa_row_q[c]  <= '0;
              px_row_q[c]  <= '0;
              sa_hold_q[c] <= '0;
              px_hold_q[c] <= '0;
              if (!accumulate) begin
                for (int r = 0; r < ROWS; r++) begin
                  sa_acc_q[r][c] <= '0;
                  px_acc_q[r][c] <= '0;
                end
              end
            end
          end
        end

        S_COLLECT: begin
          // hold counters are down-counters: zero means the next valid cycle is a fresh sample
          for (int c = 0; c < COLS; c++) begin
            if (!sa_out_valid[c]) begin
              sa_hold_q[c] <= '0;
            end else if (!stall) begin
              if (sa_hold_q[c] == '0) begin
                sa_hold_q[c] <= HOLD_W'(HOLD_CYCLES - 1);
                if (sa_row_q[c] == ROW_W'(ROWS)) begin
                  ovf_q <= 1'b1;
                end else begin
                  for (int r = 0; r < ROWS; r++) begin
                    if (sa_row_q[c] == ROW_W'(r))
                      sa_acc_q[r][c] <= add_w(sa_acc_q[r][c], sa_out[c*WORD_SIZE +: WORD_SIZE]);
                  end
                  sa_row_q[c] <= sa_row_q[c] + ROW_W'(1);
                end
              end else begin
                sa_hold_q[c] <= sa_hold_q[c] - HOLD_W'(1);
              end
            end

            if (!proxy_out_valid[c]) begin
              px_hold_q[c] <= '0;
            end else if (!stall) begin
              if (px_hold_q[c] == '0) begin
                px_hold_q[c] <= HOLD_W'(HOLD_CYCLES - 1);
                if (px_row_q[c] == ROW_W'(ROWS)) begin
                  ovf_q <= 1'b1;
                end else begin
                  for (int r = 0; r < ROWS; r++) begin
                    if (px_row_q[c] == ROW_W'(r))
                      px_acc_q[r][c] <= add_w(px_acc_q[r][c], proxy_out[c*WORD_SIZE +: WORD_SIZE]);
                  end
                  px_row_q[c] <= px_row_q[c] + ROW_W'(1);
                end
              end else begin
                px_hold_q[c] <= px_hold_q[c] - HOLD_W'(1);
              end
            end
          end
          if (fsm_done) begin
            state_q  <= S_MEM_WR;
            wr_row_q <= '0;
          end
        end

        S_MEM_WR: begin
          if (wr_row_q == ROW_W'(ROWS)) begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wr_en_q  <= 1'b1;
            addr_q   <= OUTPUT_BASE_ADDR + 32'(wr_row_q) * 32'(ADDR_INCR);
            data_q   <= row_data_d;
            wr_row_q <= wr_row_q + ROW_W'(1);
            if (MEM_ACCESS_LATENCY > 1) begin
              state_q   <= S_MEM_WR_DELAY;
              lat_cnt_q <= LAT_W'(MEM_ACCESS_LATENCY - 2);
            end
          end
        end

        S_MEM_WR_DELAY: begin
          wr_en_q <= 1'b0;
          if (lat_cnt_q == '0)
            state_q <= S_MEM_WR;
          else
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
        end

        S_DONE: begin
          done_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_output_rdy  = rdy_q;
  assign wr_output_done = done_q;
  assign overflow       = ovf_q;
  assign mem_wr_en      = wr_en_q;
  assign mem_addr       = addr_q;
  assign mem_data       = data_q;

endmodule

// File: tb/tb_matmul_output_collector.sv
// Self-checking bench for matmul_output_collector: table of tiles plus directed corner sequences,
// checked against a sample-list model of the accumulators.
module tb_matmul_output_collector;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int W    = 16;
  localparam int H    = 2;
  localparam int L    = 2;
  localparam int MPW  = 64;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int INCR = 4;
`ifdef OUTPUT_SAT_EN
  localparam logic [W-1:0] EDGE_SUM = 16'h7FFF;
`else
  localparam logic [W-1:0] EDGE_SUM = 16'h8000;
`endif

  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, start = 1'b0, accumulate = 1'b0, fsm_done = 1'b0;
  logic [COLS*W-1:0] sa_out = '0, proxy_out = '0;
  logic [COLS-1:0]   sa_out_valid = '0, proxy_out_valid = '0;
  logic              wr_output_rdy, wr_output_done, overflow, mem_wr_en;
  logic [31:0]       mem_addr;
  logic [MPW-1:0]    mem_data;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  matmul_output_collector #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .HOLD_CYCLES(H), .MEM_PORT_WIDTH(MPW),
    .OUTPUT_BASE_ADDR(BASE), .ADDR_INCR(INCR), .MEM_ACCESS_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .start(start), .accumulate(accumulate),
    .fsm_done(fsm_done), .sa_out(sa_out), .sa_out_valid(sa_out_valid),
    .proxy_out(proxy_out), .proxy_out_valid(proxy_out_valid),
    .wr_output_rdy(wr_output_rdy), .wr_output_done(wr_output_done), .overflow(overflow),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_data(mem_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: matrices of summed samples plus per-column sample counts
  logic [W-1:0]   m_sa [ROWS][COLS];
  logic [W-1:0]   m_px [ROWS][COLS];
  int             m_nsa [COLS];
  int             m_npx [COLS];
  bit             m_ovf;

  logic [W-1:0]   st_sa [COLS][8];
  logic [W-1:0]   st_px [COLS][8];
  int             n_sa [COLS];
  int             n_px [COLS];
  logic [MPW-1:0] wr_data [ROWS];

  typedef struct {
    bit           acc;
    bit           rnd;
    logic [W-1:0] sa_base;
    logic [W-1:0] sa_step;
    int           px_col;
    logic [W-1:0] px_val;
    int           col0_n;
    logic [W-1:0] exp_r0c0;
    logic [W-1:0] exp_r3c2;
    bit           exp_ovf;
  } tile_t;

  tile_t tiles[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] madd(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef OUTPUT_SAT_EN
    if (s > (2**(W-1)) - 1) s = (2**(W-1)) - 1;
    if (s < -(2**(W-1))) s = -(2**(W-1));
`endif
    return W'(s);
  endfunction

  function automatic logic [MPW-1:0] exp_row(input int r);
    logic [MPW-1:0] w;
    w = '0;
    for (int c = 0; c < COLS; c++) w[c*W +: W] = madd(m_sa[r][c], m_px[r][c]);
    return w;
  endfunction

  task automatic model_clear_acc();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_sa[r][c] = '0;
        m_px[r][c] = '0;
      end
  endtask

  task automatic model_load();
    for (int c = 0; c < COLS; c++) begin
      for (int k = 0; k < n_sa[c]; k++) begin
        if (m_nsa[c] == ROWS) m_ovf = 1'b1;
        else begin m_sa[m_nsa[c]][c] = madd(m_sa[m_nsa[c]][c], st_sa[c][k]); m_nsa[c]++; end
      end
      for (int k = 0; k < n_px[c]; k++) begin
        if (m_npx[c] == ROWS) m_ovf = 1'b1;
        else begin m_px[m_npx[c]][c] = madd(m_px[m_npx[c]][c], st_px[c][k]); m_npx[c]++; end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rdy", wr_output_rdy, 1);
    check("rst_done", wr_output_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    rst = 1'b0;
    model_clear_acc();
    m_ovf = 1'b0;
    for (int c = 0; c < COLS; c++) begin m_nsa[c] = 0; m_npx[c] = 0; end
  endtask

  task automatic do_start(input bit acc);
    @(negedge clk);
    check("rdy_idle", wr_output_rdy, 1);
    start = 1'b1;
    accumulate = acc;
    @(negedge clk);
    start = 1'b0;
    accumulate = 1'b0;
    check("rdy_busy", wr_output_rdy, 0);
    if (!acc) model_clear_acc();
    m_ovf = 1'b0;
    for (int c = 0; c < COLS; c++) begin m_nsa[c] = 0; m_npx[c] = 0; end
  endtask

  task automatic setup_tile(input tile_t t);
    for (int c = 0; c < COLS; c++) begin
      for (int k = 0; k < 8; k++) begin
        st_sa[c][k] = W'(t.sa_base + t.sa_step * W'(k));
        st_px[c][k] = t.px_val;
      end
      n_sa[c] = ROWS;
      n_px[c] = (c == t.px_col) ? ROWS : 0;
    end
    n_sa[0] = t.col0_n;
  endtask

  task automatic lane_step(input int n, input logic [W-1:0] val, input bit st, input bit rnd,
                           inout int idx, inout int rem, inout int gap,
                           output logic v, output logic [W-1:0] d);
    v = 1'b0;
    d = W'($urandom);
    if (idx < n) begin
      if (gap > 0) gap--;
      else begin
        v = 1'b1;
        d = val;
        if (!st) begin
          rem--;
          if (rem == 0) begin
            idx++;
            rem = H;
            gap = rnd ? $urandom_range(0, 2) : 0;
          end
        end
      end
    end
  endtask

  // each sample is presented for H non-stalled valid cycles, with optional idle gaps between samples
  task automatic drive_collect(input bit rnd);
    int si[COLS], sr[COLS], sg[COLS], pi[COLS], pr[COLS], pg[COLS];
    bit st, busy;
    int guard;
    logic v;
    logic [W-1:0] d;
    for (int c = 0; c < COLS; c++) begin
      si[c] = 0; pi[c] = 0; sr[c] = H; pr[c] = H;
      sg[c] = rnd ? $urandom_range(0, 2) : 0;
      pg[c] = rnd ? $urandom_range(0, 2) : 0;
    end
    guard = 0;
    busy = 1'b1;
    while (busy && guard < 600) begin
      @(negedge clk);
      guard++;
      st = rnd && ($urandom_range(0, 3) == 0);
      stall = st;
      busy = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        lane_step(n_sa[c], (si[c] < n_sa[c]) ? st_sa[c][si[c]] : '0, st, rnd, si[c], sr[c], sg[c], v, d);
        sa_out_valid[c] = v;
        sa_out[c*W +: W] = d;
        lane_step(n_px[c], (pi[c] < n_px[c]) ? st_px[c][pi[c]] : '0, st, rnd, pi[c], pr[c], pg[c], v, d);
        proxy_out_valid[c] = v;
        proxy_out[c*W +: W] = d;
        if (si[c] < n_sa[c] || pi[c] < n_px[c]) busy = 1'b1;
      end
    end
    check("collect_budget", 64'(busy), 0);
  endtask

  task automatic check_writeout(input int n0, input bit rnd);
    int ns, nd;
    ns = 0;
    nd = 0;
    for (int r = 0; r < ROWS; r++) wr_data[r] = '0;
    for (int k = 0; k < ROWS*L + 6; k++) begin
      if (k > 0) @(negedge clk);
      stall = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mem_wr_en) begin
        if (ns < ROWS) begin
          check("strobe_time", 64'(cyc), 64'(n0 + 1 + ns*L));
          check("strobe_addr", mem_addr, BASE + 32'(ns * INCR));
          check("strobe_data", mem_data, exp_row(ns));
          wr_data[ns] = mem_data;
        end
        ns++;
      end
      if (wr_output_done) begin
        check("done_time", 64'(cyc), 64'(n0 + 1 + ROWS*L));
        nd++;
      end
    end
    stall = 1'b0;
    check("strobe_count", 64'(ns), ROWS);
    check("done_count", 64'(nd), 1);
    check("rdy_after", wr_output_rdy, 1);
    check("overflow", overflow, 64'(m_ovf));
  endtask

  task automatic finish_tile(input bit rnd);
    int n0;
    @(negedge clk);
    sa_out_valid = '0;
    proxy_out_valid = '0;
    stall = 1'b0;
    fsm_done = 1'b1;
    n0 = cyc + 1;
    @(negedge clk);
    fsm_done = 1'b0;
    check_writeout(n0, rnd);
  endtask

  initial begin
    int n0, seen;
    tiles[0] = '{0, 0, 16'd1,     16'd1,     -1, 16'd0,     4, 16'd1,     16'd4,     0};
    tiles[1] = '{0, 0, 16'd5,     16'd0,      2, 16'd10,    4, 16'd5,     16'd15,    0};
    tiles[2] = '{1, 0, 16'd5,     16'd0,      2, 16'd10,    4, 16'd10,    16'd30,    0};
    tiles[3] = '{0, 0, 16'd5,     16'd0,      2, 16'd10,    4, 16'd5,     16'd15,    0};
    tiles[4] = '{0, 0, 16'd1,     16'd1,     -1, 16'd0,     5, 16'd1,     16'd4,     1};
    tiles[5] = '{0, 0, 16'h7FFF,  16'd0,      2, 16'd1,     4, 16'h7FFF,  EDGE_SUM,  0};
    tiles[6] = '{0, 1, 16'h1234,  16'h0101,   1, 16'h0200,  4, 16'h1234,  16'h1537,  0};
    tiles[7] = '{1, 1, 16'h1234,  16'h0101,   1, 16'h0200,  4, 16'h2468,  16'h2A6E,  0};

    do_reset();

    for (int t = 0; t < 8; t++) begin
      setup_tile(tiles[t]);
      do_start(tiles[t].acc);
      drive_collect(tiles[t].rnd);
      model_load();
      finish_tile(tiles[t].rnd);
      check("tile_r0c0", wr_data[0][W-1:0], tiles[t].exp_r0c0);
      check("tile_r3c2", wr_data[ROWS-1][2*W +: W], tiles[t].exp_r3c2);
      check("tile_ovf", overflow, 64'(tiles[t].exp_ovf));
    end

    // last sample's first cycle coincides with fsm_done: the capture must survive
    for (int c = 0; c < COLS; c++) begin
      for (int k = 0; k < 8; k++) st_sa[c][k] = 16'd7;
      st_sa[c][3] = 16'd9;
      n_sa[c] = 3;
      n_px[c] = 0;
    end
    do_start(1'b0);
    drive_collect(1'b0);
    for (int c = 0; c < COLS; c++) n_sa[c] = 4;
    model_load();
    @(negedge clk);
    sa_out_valid = '1;
    sa_out = {COLS{16'd9}};
    fsm_done = 1'b1;
    n0 = cyc + 1;
    @(negedge clk);
    fsm_done = 1'b0;
    sa_out_valid = '0;
    check_writeout(n0, 1'b0);
    check("same_cycle_r3", wr_data[3][W-1:0], 16'd9);

    // in IDLE, fsm_done and valids are ignored; an empty accumulate tile rewrites the same matrix
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_wr_en) seen++;
      sa_out_valid = (k < 4) ? COLS'($urandom) : '0;
      proxy_out_valid = (k < 4) ? COLS'($urandom) : '0;
      sa_out = {COLS{16'h0055}};
      proxy_out = {COLS{16'h0033}};
      fsm_done = (k < 4);
    end
    check("idle_no_strobe", 64'(seen), 0);
    check("idle_rdy", wr_output_rdy, 1);
    for (int c = 0; c < COLS; c++) begin n_sa[c] = 0; n_px[c] = 0; end
    do_start(1'b1);
    drive_collect(1'b0);
    model_load();
    finish_tile(1'b0);
    check("retained_r3", wr_data[3][W-1:0], 16'd9);

    // reset after the second strobe aborts the write-out
    setup_tile('{0, 0, 16'h0011, 16'd1, 3, 16'd2, 4, 16'd0, 16'd0, 0});
    do_start(1'b0);
    drive_collect(1'b0);
    model_load();
    @(negedge clk);
    sa_out_valid = '0;
    proxy_out_valid = '0;
    fsm_done = 1'b1;
    @(negedge clk);
    fsm_done = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen < 2; k++) begin
      @(negedge clk);
      if (mem_wr_en) seen++;
    end
    check("second_strobe_seen", 64'(seen), 2);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rdy", wr_output_rdy, 1);
    check("abort_done", wr_output_done, 0);
    check("abort_ovf", overflow, 0);
    check("abort_wr_en", mem_wr_en, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_data", mem_data, 0);
    rst = 1'b0;
    model_clear_acc();
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_wr_en || wr_output_done) seen++;
    end
    check("abort_quiet", 64'(seen), 0);

    // accumulate after reset must start from zero
    setup_tile('{1, 0, 16'd3, 16'd0, -1, 16'd0, 4, 16'd0, 16'd0, 0});
    do_start(1'b1);
    drive_collect(1'b0);
    model_load();
    finish_tile(1'b0);
    check("post_reset_acc", wr_data[2][W +: W], 16'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
